// File: rtl/alu_ex_stage.sv
// alu_ex_stage: registered execute stage between register-file read and
// write ports. Applies one of eight ALU ops, keeps an NZCV flags register
// and supports stall/flush. Optional feature macro: EX_FORWARD_EN
// (forwards the pending writeback onto the operands of the next instruction).
`timescale 1ns/1ps
module alu_ex_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        alu_op,
    input  logic              set_flags,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wb_en_in,
    input  logic [ADDR_W-1:0] wb_addr_in,
    output logic              out_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [WIDTH-1:0]  write_data,
    output logic [3:0]        flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_MVN = 3'b111;

    logic              out_valid_q, out_valid_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [WIDTH-1:0]  write_data_q, write_data_d;
    logic [3:0]        flags_q,     flags_d;

    logic [WIDTH-1:0]  a_opnd, b_opnd;

`ifdef EX_FORWARD_EN
    // The pending writeback is not yet in the register file, so a matching
    // read address sees stale data; substitute the registered result.
    assign a_opnd = (wr_en_q && (write_addr_q == rd_addr1)) ? write_data_q : op_a;
    assign b_opnd = (wr_en_q && (write_addr_q == rd_addr2)) ? write_data_q : op_b;
`else
    // Without forwarding the read addresses are ignored; the issue logic
    // inserts a bubble between producer and consumer instead.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign a_opnd = op_a;
    assign b_opnd = op_b;
`endif

    logic              is_sub, is_arith;
    logic [WIDTH-1:0]  b_add;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  result;
    logic              v_add, v_sub;
    logic [3:0]        flags_new;

    // ALU: single WIDTH+1 adder shared by ADD/SUB/CMP, plus logical ops.
    always_comb begin
        is_sub   = (alu_op == OP_SUB) || (alu_op == OP_CMP);
        is_arith = (alu_op == OP_ADD) || is_sub;
        b_add    = is_sub ? ~b_opnd : b_opnd;
        sum      = {1'b0, a_opnd} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
        result   = sum[WIDTH-1:0];
        case (alu_op)
            OP_AND:  result = a_opnd & b_opnd;
            OP_ORR:  result = a_opnd | b_opnd;
            OP_EOR:  result = a_opnd ^ b_opnd;
            OP_MOV:  result = b_opnd;
            OP_MVN:  result = ~b_opnd;
            default: result = sum[WIDTH-1:0];
        endcase
        v_add = (a_opnd[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != a_opnd[WIDTH-1]);
        v_sub = (a_opnd[WIDTH-1] != b_opnd[WIDTH-1]) && (sum[WIDTH-1] != a_opnd[WIDTH-1]);
        // Logical ops keep C and V from the last arithmetic op.
        flags_new = {result[WIDTH-1],
                     (result == '0),
                     is_arith ? sum[WIDTH] : flags_q[1],
                     is_arith ? (is_sub ? v_sub : v_add) : flags_q[0]};
    end

    // Next state: flush beats stall; stall holds everything.
    always_comb begin
        out_valid_d  = out_valid_q;
        wr_en_d      = wr_en_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        flags_d      = flags_q;
        if (flush) begin
            out_valid_d = 1'b0;
            wr_en_d     = 1'b0;
        end else if (!stall) begin
            out_valid_d  = in_valid;
            wr_en_d      = in_valid && wb_en_in && (alu_op != OP_CMP);
            write_addr_d = wb_addr_in;
            write_data_d = result;
            if (in_valid && set_flags) begin
                flags_d = flags_new;
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            flags_q      <= 4'b0000;
        end else begin
            out_valid_q  <= out_valid_d;
            wr_en_q      <= wr_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign wr_en      = wr_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed testbench for alu_ex_stage. Expected values are hand-computed;
// forwarding expectations follow the EX_FORWARD_EN macro.
`timescale 1ns/1ps
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, stall, flush, set_flags, wb_en_in;
    logic [2:0]  alu_op;
    logic [31:0] op_a, op_b;
    logic [3:0]  rd_addr1, rd_addr2, wb_addr_in;
    logic        out_valid, wr_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ex_stage #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .flush(flush), .alu_op(alu_op), .set_flags(set_flags),
        .op_a(op_a), .op_b(op_b), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .out_valid(out_valid),
        .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data),
        .flags(flags)
    );

    // Present one instruction, then advance one edge and settle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sf, input logic wb, input logic [3:0] wa,
                         input logic [3:0] r1, input logic [3:0] r2);
        in_valid = 1'b1; alu_op = op; op_a = a; op_b = b; set_flags = sf;
        wb_en_in = wb; wb_addr_in = wa; rd_addr1 = r1; rd_addr2 = r2;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; stall = 0; flush = 0; set_flags = 0; wb_en_in = 0;
        alu_op = 3'b000; op_a = 0; op_b = 0; rd_addr1 = 0; rd_addr2 = 0; wb_addr_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, wr_en, write_addr, write_data, flags} !== {1'b0, 1'b0, 4'h0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_state: got v=%b we=%b a=%h d=%h f=%b want all zero",
                     out_valid, wr_en, write_addr, write_data, flags);
        end
    endtask

    task automatic test_add_overflow();
        issue(3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0);
        checks++;
        if ({out_valid, wr_en, write_addr, write_data} !== {1'b1, 1'b1, 4'd3, 32'h8000_0000}) begin
            failures++;
            $display("FAIL add_result: got v=%b we=%b a=%0d d=%h want v=1 we=1 a=3 d=80000000",
                     out_valid, wr_en, write_addr, write_data);
        end
        checks++;
        if (flags !== 4'b1001) begin
            failures++;
            $display("FAIL add_flags: got %b want 1001", flags);
        end
    endtask

    task automatic test_flags_retention();
        issue(3'b001, 32'd5, 32'd5, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0);
        checks++;
        if ({write_data, flags} !== {32'h0, 4'b0110}) begin
            failures++;
            $display("FAIL sub_flags: got d=%h f=%b want d=0 f=0110", write_data, flags);
        end
        issue(3'b010, 32'hF0, 32'h0F, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0);
        checks++;
        if ({write_data, flags} !== {32'h0, 4'b0110}) begin
            failures++;
            $display("FAIL and_flags: got d=%h f=%b want d=0 f=0110", write_data, flags);
        end
        issue(3'b011, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 4'd6, 4'd0, 4'd0);
        checks++;
        if ({write_addr, write_data, flags} !== {4'd6, 32'h8000_0000, 4'b1010}) begin
            failures++;
            $display("FAIL orr_flags: got a=%0d d=%h f=%b want a=6 d=80000000 f=1010",
                     write_addr, write_data, flags);
        end
        // MVN and EOR without set_flags: data only, flags untouched
        issue(3'b111, 32'h0, 32'h0000_FFFF, 1'b0, 1'b1, 4'd7, 4'd0, 4'd0);
        checks++;
        if ({write_data, flags} !== {32'hFFFF_0000, 4'b1010}) begin
            failures++;
            $display("FAIL mvn_noflags: got d=%h f=%b want d=ffff0000 f=1010", write_data, flags);
        end
        issue(3'b100, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd0);
        checks++;
        if (write_data !== 32'hF0F0_F0F0) begin
            failures++;
            $display("FAIL eor_data: got %h want f0f0f0f0", write_data);
        end
    endtask

    task automatic test_stall();
        // Stage holds EOR result to r6 with wr_en=1, flags 1010.
        stall = 1'b1;
        in_valid = 1'b1; alu_op = 3'b000; op_a = 32'd2; op_b = 32'd3;
        set_flags = 1'b1; wb_en_in = 1'b1; wb_addr_in = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, wr_en, write_addr, write_data, flags} !==
                {1'b1, 1'b1, 4'd6, 32'hF0F0_F0F0, 4'b1010}) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b we=%b a=%0d d=%h f=%b want 1 1 6 f0f0f0f0 1010",
                         i, out_valid, wr_en, write_addr, write_data, flags);
            end
        end
        stall = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({wr_en, write_addr, write_data, flags} !== {1'b1, 4'd5, 32'd5, 4'b0000}) begin
            failures++;
            $display("FAIL stall_release: got we=%b a=%0d d=%h f=%b want 1 5 00000005 0000",
                     wr_en, write_addr, write_data, flags);
        end
    endtask

    task automatic test_cmp();
        issue(3'b110, 32'd3, 32'd4, 1'b1, 1'b1, 4'd8, 4'd0, 4'd0);
        checks++;
        if ({out_valid, wr_en, flags} !== {1'b1, 1'b0, 4'b1000}) begin
            failures++;
            $display("FAIL cmp: got v=%b we=%b f=%b want v=1 we=0 f=1000", out_valid, wr_en, flags);
        end
    endtask

    task automatic test_flush();
        issue(3'b101, 32'h0, 32'h55, 1'b0, 1'b1, 4'd9, 4'd0, 4'd0);
        checks++;
        if ({wr_en, write_addr, write_data} !== {1'b1, 4'd9, 32'h55}) begin
            failures++;
            $display("FAIL mov_pre_flush: got we=%b a=%0d d=%h want 1 9 00000055", wr_en, write_addr, write_data);
        end
        flush = 1'b1; stall = 1'b1;
        issue(3'b001, 32'd0, 32'd1, 1'b1, 1'b1, 4'd10, 4'd0, 4'd0);
        flush = 1'b0; stall = 1'b0;
        checks++;
        if ({out_valid, wr_en, flags} !== {1'b0, 1'b0, 4'b1000}) begin
            failures++;
            $display("FAIL flush_stall: got v=%b we=%b f=%b want v=0 we=0 f=1000", out_valid, wr_en, flags);
        end
        // Idle cycle: address/data still load, qualifiers low
        in_valid = 1'b0; wb_addr_in = 4'd11; op_a = 32'd1; op_b = 32'd1; alu_op = 3'b000;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, wr_en, write_addr, write_data} !== {1'b0, 1'b0, 4'd11, 32'd2}) begin
            failures++;
            $display("FAIL idle_load: got v=%b we=%b a=%0d d=%h want 0 0 11 00000002",
                     out_valid, wr_en, write_addr, write_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp2, exp3;
`ifdef EX_FORWARD_EN
        exp2 = 32'h20; exp3 = 32'h21;
`else
        exp2 = 32'h00; exp3 = 32'h01;
`endif
        issue(3'b101, 32'h0, 32'h10, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0);
        checks++;
        if ({wr_en, write_addr, write_data} !== {1'b1, 4'd1, 32'h10}) begin
            failures++;
            $display("FAIL fwd_producer: got we=%b a=%0d d=%h want 1 1 00000010", wr_en, write_addr, write_data);
        end
        issue(3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 4'd2, 4'd1, 4'd1);
        checks++;
        if (write_data !== exp2) begin
            failures++;
            $display("FAIL fwd_both: got %h want %h", write_data, exp2);
        end
        issue(3'b000, 32'h0, 32'h1, 1'b0, 1'b1, 4'd3, 4'd2, 4'd7);
        checks++;
        if (write_data !== exp3) begin
            failures++;
            $display("FAIL fwd_a_only: got %h want %h", write_data, exp3);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, wr_en, write_addr, write_data, flags} !== {1'b0, 1'b0, 4'h0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL async_reset: got v=%b we=%b a=%h d=%h f=%b want all zero",
                     out_valid, wr_en, write_addr, write_data, flags);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_flags_retention();
        test_stall();
        test_cmp();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
